// File: rtl/mlaccel_spi_pkg.sv
// rtl/mlaccel_spi_pkg.sv - shared types and constants for the SPI slave front end
package mlaccel_spi_pkg;

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int BYTE_W = 8;

  // {CPOL, CPHA}; CPOL also fixes the idle level the SCK synchroniser resets to
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  function automatic int edges_per_byte(input int lanes);
    return BYTE_W / lanes;
  endfunction

endpackage

// File: rtl/mlaccel_spi_sync_in.sv
// rtl/mlaccel_spi_sync_in.sv - multi-flop input synchroniser with optional single-cycle edge pulses
module mlaccel_spi_sync_in #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter bit               EDGE_DET  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced,
  output logic             rise,
  output logic             fall
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= raw;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign synced = stage[STAGES-1];

  generate
    if (EDGE_DET) begin : g_edge
      logic prev;
      always_ff @(posedge clock) begin
        if (reset) prev <= RESET_VAL[0];
        else       prev <= synced[0];
      end
      assign rise = synced[0] & ~prev;
      assign fall = ~synced[0] & prev;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mlaccel_spi_sync.sv
// rtl/mlaccel_spi_sync.sv - oversampled mode-0 SPI slave (1/2/4 lanes) with din/dout handshakes
module mlaccel_spi_sync
  import mlaccel_spi_pkg::*;
#(
  parameter int         LANES       = 1,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             spi_csb,
  input  logic             spi_clk,
  input  logic [LANES-1:0] spi_mosi,
  output logic [LANES-1:0] spi_miso,
  output logic [LANES-1:0] spi_oe,
  output logic             spi_rdy,
  output logic             spi_err,
  output logic             active,
  output logic             din_valid,
  input  logic             din_ready,
  output logic             din_start,
  output logic [7:0]       din_data,
  input  logic             dout_valid,
  output logic             dout_ready,
  input  logic [7:0]       dout_data
);

  localparam logic [2:0] LAST_CNT = 3'((edges_per_byte(LANES) - 1) * LANES);

  state_t           state, state_nxt;
  logic             sck_lvl_unused, sck_rise, sck_fall;
  logic             csb_lvl_unused, csb_rise, csb_fall;
  logic [LANES-1:0] mosi_s;
  logic             mosi_rise_unused, mosi_fall_unused;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_sr, tx_sr, hold, rx_shift, tx_load;
  logic             hold_full, start_flag, byte_done, boundary;

  mlaccel_spi_sync_in #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE_DET(1'b1), .RESET_VAL(SPI_MODE0[1]))
    u_sck (.clock(clock), .reset(reset), .raw(spi_clk), .synced(sck_lvl_unused),
           .rise(sck_rise), .fall(sck_fall));

  mlaccel_spi_sync_in #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE_DET(1'b1), .RESET_VAL(1'b1))
    u_csb (.clock(clock), .reset(reset), .raw(spi_csb), .synced(csb_lvl_unused),
           .rise(csb_rise), .fall(csb_fall));

  mlaccel_spi_sync_in #(.WIDTH(LANES), .STAGES(SYNC_STAGES), .EDGE_DET(1'b0), .RESET_VAL({LANES{1'b0}}))
    u_mosi (.clock(clock), .reset(reset), .raw(spi_mosi), .synced(mosi_s),
            .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csb_fall) state_nxt = ACTIVE;
      ACTIVE:  if (csb_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_shift  = {rx_sr[BYTE_W-LANES-1:0], mosi_s};
  assign tx_load   = hold_full ? hold : IDLE_BYTE;
  assign byte_done = (bit_cnt == LAST_CNT);
  assign boundary  = (bit_cnt == 3'd0);

  assign active     = (state == ACTIVE);
  assign spi_miso   = tx_sr[BYTE_W-1 -: LANES];
  assign dout_ready = !hold_full && !reset;
  assign spi_rdy    = active && !din_valid && hold_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= IDLE_BYTE;
      hold       <= '0;
      hold_full  <= 1'b0;
      start_flag <= 1'b0;
      spi_oe     <= '0;
      spi_err    <= 1'b0;
      din_valid  <= 1'b0;
      din_start  <= 1'b0;
      din_data   <= '0;
    end else begin
      if (din_valid && din_ready) din_valid <= 1'b0;
      // A reload in the same cycle as an accept sees the empty register; the new byte waits
      if (dout_valid && dout_ready) begin
        hold      <= dout_data;
        hold_full <= 1'b1;
      end
      if (csb_fall) begin
        bit_cnt    <= '0;
        start_flag <= 1'b1;
        spi_err    <= 1'b0;
        spi_oe     <= '1;
        tx_sr      <= tx_load;
        if (hold_full) hold_full <= 1'b0;
      end else if (state == ACTIVE) begin
        if (csb_rise) begin
          bit_cnt <= '0;
          spi_oe  <= '0;
        end else begin
          if (sck_rise) begin
            rx_sr   <= rx_shift;
            bit_cnt <= byte_done ? 3'd0 : bit_cnt + 3'(LANES);
            if (byte_done) begin
              if (!din_valid) begin
                din_data  <= rx_shift;
                din_start <= start_flag;
                din_valid <= 1'b1;
              end else begin
                spi_err <= 1'b1;
              end
              start_flag <= 1'b0;
            end
          end
          if (sck_fall) begin
            if (boundary) begin
              tx_sr <= tx_load;
              if (hold_full) hold_full <= 1'b0;
              else           spi_err   <= 1'b1;
            end else begin
              tx_sr <= {tx_sr[BYTE_W-LANES-1:0], {LANES{1'b0}}};
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mlaccel_spi_sync.sv
// tb/tb_mlaccel_spi_sync.sv - scoreboard bench for single- and quad-lane instances of mlaccel_spi_sync
module tb_mlaccel_spi_sync;

  logic       clock, reset, sck;
  logic       csb1, csb4;
  logic [0:0] mosi1, miso1, oe1;
  logic [3:0] mosi4, miso4, oe4;
  logic       rdy1, err1, active1, din_valid1, din_ready1, din_start1, dout_valid1, dout_ready1;
  logic       rdy4, err4, active4, din_valid4, din_ready4, din_start4, dout_valid4, dout_ready4;
  logic [7:0] din_data1, dout_data1, din_data4, dout_data4;

  int checks = 0;
  int errors = 0;
  int pops1  = 0;
  int pops4  = 0;
  logic [8:0] q1[$];
  logic [8:0] q4[$];

  mlaccel_spi_sync #(.LANES(1), .SYNC_STAGES(2), .IDLE_BYTE(8'h00)) u1 (
    .clock(clock), .reset(reset), .spi_csb(csb1), .spi_clk(sck), .spi_mosi(mosi1),
    .spi_miso(miso1), .spi_oe(oe1), .spi_rdy(rdy1), .spi_err(err1), .active(active1),
    .din_valid(din_valid1), .din_ready(din_ready1), .din_start(din_start1), .din_data(din_data1),
    .dout_valid(dout_valid1), .dout_ready(dout_ready1), .dout_data(dout_data1));

  mlaccel_spi_sync #(.LANES(4), .SYNC_STAGES(2), .IDLE_BYTE(8'h00)) u4 (
    .clock(clock), .reset(reset), .spi_csb(csb4), .spi_clk(sck), .spi_mosi(mosi4),
    .spi_miso(miso4), .spi_oe(oe4), .spi_rdy(rdy4), .spi_err(err4), .active(active4),
    .din_valid(din_valid4), .din_ready(din_ready4), .din_start(din_start4), .din_data(din_data4),
    .dout_valid(dout_valid4), .dout_ready(dout_ready4), .dout_data(dout_data4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_extra(input string name, input logic [8:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got {start,data}=%0h expected no byte", name, act);
  endtask

  // Scoreboard monitor: every din handshake must match the oldest expected byte
  always @(negedge clock) begin : monitor
    logic [8:0] e;
    if (!reset && din_valid1 && din_ready1) begin
      pops1++;
      if (q1.size() == 0) fail_extra("din1_unexpected", {din_start1, din_data1});
      else begin
        e = q1.pop_front();
        check("din1_data", din_data1, e[7:0]);
        check("din1_start", din_start1, e[8]);
      end
    end
    if (!reset && din_valid4 && din_ready4) begin
      pops4++;
      if (q4.size() == 0) fail_extra("din4_unexpected", {din_start4, din_data4});
      else begin
        e = q4.pop_front();
        check("din4_data", din_data4, e[7:0]);
        check("din4_start", din_start4, e[8]);
      end
    end
  end

  function automatic logic dv(input int which);
    return (which == 1) ? din_valid1 : din_valid4;
  endfunction

  // One SCK period of 8 clocks: data set while low, optional miso check before the rise,
  // optional din latency check (valid exactly one cycle after the synced rise pulse)
  task automatic bit_cycle(input int which, input logic [3:0] val, input logic [3:0] exp_miso,
                           input bit chk_miso, input bit chk_din);
    if (which == 1) mosi1 = val[0:0];
    else            mosi4 = val;
    repeat (3) @(posedge clock);
    @(negedge clock);
    if (chk_miso) check((which == 1) ? "miso1" : "miso4",
                        (which == 1) ? {3'b000, miso1} : miso4, exp_miso);
    @(posedge clock); #1 sck = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    if (chk_din) check("din_early", dv(which), 1'b0);
    @(posedge clock);
    @(negedge clock);
    if (chk_din) check("din_latency", dv(which), 1'b1);
    @(posedge clock); #1 sck = 1'b0;
  endtask

  task automatic send_byte1(input logic [7:0] b, input bit chk_miso, input logic [7:0] exp_tx,
                            input bit chk_din);
    for (int i = 7; i >= 0; i--)
      bit_cycle(1, {3'b000, b[i]}, {3'b000, exp_tx[i]}, chk_miso, chk_din && (i == 0));
  endtask

  task automatic frame_start(input int which);
    @(posedge clock); #1;
    if (which == 1) csb1 = 1'b0;
    else            csb4 = 1'b0;
    repeat (6) @(posedge clock);
    #1;
  endtask

  task automatic frame_end(input int which);
    repeat (4) @(posedge clock); #1;
    if (which == 1) csb1 = 1'b1;
    else            csb4 = 1'b1;
    repeat (6) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; sck = 1'b0; csb1 = 1'b1; csb4 = 1'b1;
    mosi1 = '0; mosi4 = '0;
    din_ready1 = 1'b0; dout_valid1 = 1'b0; dout_data1 = '0;
    din_ready4 = 1'b0; dout_valid4 = 1'b0; dout_data4 = '0;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_active", active1, 0);
    check("rst_oe", oe1, 0);
    check("rst_err", err1, 0);
    check("rst_din_valid", din_valid1, 0);
    check("rst_dout_ready", dout_ready1, 0);
    check("rst_miso4", miso4, 4'h0);
    @(posedge clock); #1 reset = 1'b0;

    // Two full bytes, response register continuously refilled with 0xC3
    dout_data1 = 8'hC3; dout_valid1 = 1'b1; din_ready1 = 1'b1;
    repeat (2) @(posedge clock); #1;
    frame_start(1);
    @(negedge clock);
    check("t1_active", active1, 1);
    check("t1_oe", oe1, 1);
    check("t1_rdy", rdy1, 1);
    q1.push_back({1'b1, 8'hA5});
    send_byte1(8'hA5, 1'b1, 8'hC3, 1'b1);
    q1.push_back({1'b0, 8'h3C});
    send_byte1(8'h3C, 1'b1, 8'hC3, 1'b1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("t1_err", err1, 0);
    frame_end(1);
    @(negedge clock);
    check("t1_oe_off", oe1, 0);
    check("t1_inactive", active1, 0);

    // Overrun: consumer stalled across three bytes
    din_ready1 = 1'b0;
    frame_start(1);
    q1.push_back({1'b1, 8'h11});
    send_byte1(8'h11, 1'b0, 8'h00, 1'b1);
    @(negedge clock);
    check("t3_err_b1", err1, 0);
    check("t3_rdy_pending", rdy1, 0);
    send_byte1(8'h22, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("t3_err_b2", err1, 1);
    send_byte1(8'h33, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("t3_hold_valid", din_valid1, 1);
    check("t3_hold_data", din_data1, 8'h11);
    check("t3_hold_start", din_start1, 1);
    frame_end(1);
    @(negedge clock);
    check("t3_err_sticky", err1, 1);
    check("t3_valid_after_csb", din_valid1, 1);
    @(posedge clock); #1 din_ready1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("t3_valid_cleared", din_valid1, 0);
    dout_valid1 = 1'b0;

    // Underrun: 0xC3 still held from before; nothing queued for the second byte
    frame_start(1);
    @(negedge clock);
    check("t4_err_cleared", err1, 0);
    check("t4_dout_ready", dout_ready1, 1);
    q1.push_back({1'b1, 8'h96});
    send_byte1(8'h96, 1'b1, 8'hC3, 1'b1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("t4_miso_idle", miso1, 1'b0);
    check("t4_err_underrun", err1, 1);
    check("t4_dout_ready_end", dout_ready1, 1);
    frame_end(1);

    // Partial byte is discarded; next frame starts cleanly
    frame_start(1);
    bit_cycle(1, 4'h1, 4'h0, 1'b0, 1'b0);
    bit_cycle(1, 4'h0, 4'h0, 1'b0, 1'b0);
    bit_cycle(1, 4'h1, 4'h0, 1'b0, 1'b0);
    bit_cycle(1, 4'h1, 4'h0, 1'b0, 1'b0);
    bit_cycle(1, 4'h0, 4'h0, 1'b0, 1'b0);
    frame_end(1);
    @(negedge clock);
    check("t5_no_partial", din_valid1, 0);
    frame_start(1);
    q1.push_back({1'b1, 8'h81});
    send_byte1(8'h81, 1'b0, 8'h00, 1'b1);
    frame_end(1);

    // Reset mid-byte with a full holding register
    dout_data1 = 8'hFF; dout_valid1 = 1'b1;
    @(posedge clock); #1 dout_valid1 = 1'b0;
    frame_start(1);
    dout_data1 = 8'hEE; dout_valid1 = 1'b1;
    @(posedge clock); #1 dout_valid1 = 1'b0;
    bit_cycle(1, 4'h1, 4'h1, 1'b1, 1'b0);
    bit_cycle(1, 4'h1, 4'h1, 1'b1, 1'b0);
    bit_cycle(1, 4'h1, 4'h1, 1'b1, 1'b0);
    @(posedge clock); #1 reset = 1'b1; csb1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("t6_active", active1, 0);
    check("t6_oe", oe1, 0);
    check("t6_miso", miso1, 1'b0);
    check("t6_din_valid", din_valid1, 0);
    check("t6_dout_ready", dout_ready1, 0);
    check("t6_rdy", rdy1, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("t6_hold_cleared", dout_ready1, 1);
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("t6_still_idle", active1, 0);
    frame_start(1);
    q1.push_back({1'b1, 8'h3C});
    send_byte1(8'h3C, 1'b0, 8'h00, 1'b1);
    frame_end(1);

    // Quad lane: preloaded 0x5A out, nibbles 7,E in
    din_ready4 = 1'b1;
    dout_data4 = 8'h5A; dout_valid4 = 1'b1;
    @(posedge clock); #1 dout_valid4 = 1'b0;
    @(negedge clock);
    check("t2_hold_full", dout_ready4, 0);
    frame_start(4);
    @(negedge clock);
    check("t2_oe", oe4, 4'hF);
    q4.push_back({1'b1, 8'h7E});
    bit_cycle(4, 4'h7, 4'h5, 1'b1, 1'b0);
    bit_cycle(4, 4'hE, 4'hA, 1'b1, 1'b1);
    @(negedge clock);
    check("t2_oe_frame", oe4, 4'hF);
    frame_end(4);
    @(negedge clock);
    check("t2_oe_off", oe4, 4'h0);

    repeat (4) @(posedge clock);
    @(negedge clock);
    check("sb1_drained", q1.size(), 0);
    check("sb4_drained", q4.size(), 0);
    check("sb1_count", pops1, 6);
    check("sb4_count", pops4, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
